// File: rtl/minterm_sweep_checker_pkg.sv
// Purpose : shared types and helpers for the minimization sweep harness.
// Latency : n/a (declarations only).
// Backpressure: n/a; holds the sweep state enum, size limits and a vector-count helper.
package minimization_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  localparam int MAX_N      = 8;
  localparam int MAX_SETTLE = 15;

  // Number of input vectors for an n-input function.
  function automatic int num_vectors(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/minterm_sweep_checker_if.sv
// Purpose : bundles the stimulus/response wires between the sweep checker and the two circuits.
// Latency : n/a (wires only).
// Backpressure: none; start is a level sampled by the checker, F inputs are combinational.
// Ports   : master = checker side (drives abc and results), slave = environment side
//           (drives start and both F outputs, observes everything else).
interface minterm_sweep_checker_if
  import minimization_pkg::*;
#(
  parameter int N = 3
);
  logic                      start;
  logic                      f_orig;
  logic                      f_simp;
  logic [N-1:0]              abc;
  logic                      busy;
  logic                      done;
  logic                      pass;
  logic [N:0]                mismatch_cnt;
  logic [N-1:0]              first_fail;
  logic [num_vectors(N)-1:0] truth_orig;
  logic [num_vectors(N)-1:0] truth_simp;

  modport master (
    input  start, f_orig, f_simp,
    output abc, busy, done, pass, mismatch_cnt, first_fail, truth_orig, truth_simp
  );

  modport slave (
    output start, f_orig, f_simp,
    input  abc, busy, done, pass, mismatch_cnt, first_fail, truth_orig, truth_simp
  );
endinterface

// File: rtl/minterm_sweep_checker_settle_timer.sv
// Purpose : 4-bit loadable down-counter pacing the settle window of each vector.
// Latency : expired is high while the count sits at 1, i.e. value-1 cycles after the load edge.
// Backpressure: none; a load always wins over counting, the counter parks at 0.
// Ports   : clk, rst_n, load (reload with value), value (settle cycles), expired (sample due).
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] value,
  output logic       expired
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Reaching 1 means the last settle cycle is in progress; the next cycle samples.
  assign expired = (cnt_q == 4'd1);

endmodule

// File: rtl/minterm_sweep_checker.sv
// Purpose : exhaustive sweep of all 2^N input vectors, comparing original vs simplified F.
// Latency : done rises 2^N*(SETTLE+1) cycles after the accepted start edge.
// Backpressure: start is ignored while busy; results hold until the next accepted start.
// Ports   : clk, rst_n (async active-low), bus (master modport: start/f_orig/f_simp in,
//           abc/busy/done/pass/mismatch_cnt/first_fail/truth_orig/truth_simp out).
module minterm_sweep_checker
  import minimization_pkg::*;
#(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  minterm_sweep_checker_if.master        bus
);

  localparam int NV = num_vectors(N);
  localparam int CW = N + 1;

  sweep_state_t    state_q, state_d;
  logic [N-1:0]    abc_q, abc_d;
  logic [CW-1:0]   mcnt_q, mcnt_d;
  logic [N-1:0]    ff_q, ff_d;
  logic [NV-1:0]   to_q, to_d;
  logic [NV-1:0]   ts_q, ts_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic            timer_load;
  logic            timer_expired;
  logic            mismatch;
  logic [CW-1:0]   mcnt_next;
  logic            last_vec;

  settle_timer u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .value   (4'(SETTLE)),
    .expired (timer_expired)
  );

  assign mismatch  = (bus.f_orig != bus.f_simp);
  assign mcnt_next = mcnt_q + CW'(mismatch);
  // Terminal compare keeps the N-bit index from wrapping past the last vector.
  assign last_vec  = (abc_q == N'(NV - 1));

  always_comb begin
    state_d    = state_q;
    abc_d      = abc_q;
    mcnt_d     = mcnt_q;
    ff_d       = ff_q;
    to_d       = to_q;
    ts_d       = ts_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timer_load = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          abc_d  = '0;
          mcnt_d = '0;
          ff_d   = '0;
          to_d   = '0;
          ts_d   = '0;
          done_d = 1'b0;
          pass_d = 1'b0;
          if (SETTLE == 0) begin
            state_d = ST_SAMPLE;
          end else begin
            state_d    = ST_WAIT;
            timer_load = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (timer_expired) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        to_d[abc_q] = bus.f_orig;
        ts_d[abc_q] = bus.f_simp;
        mcnt_d      = mcnt_next;
        // An all-zero count before this vector marks it as the first failure.
        if (mismatch && (mcnt_q == '0)) begin
          ff_d = abc_q;
        end
        if (last_vec) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (mcnt_next == '0);
        end else begin
          abc_d = abc_q + N'(1);
          if (SETTLE == 0) begin
            state_d = ST_SAMPLE;
          end else begin
            state_d    = ST_WAIT;
            timer_load = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      abc_q   <= '0;
      mcnt_q  <= '0;
      ff_q    <= '0;
      to_q    <= '0;
      ts_q    <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      abc_q   <= abc_d;
      mcnt_q  <= mcnt_d;
      ff_q    <= ff_d;
      to_q    <= to_d;
      ts_q    <= ts_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.abc          = abc_q;
  assign bus.busy         = (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.mismatch_cnt = mcnt_q;
  assign bus.first_fail   = ff_q;
  assign bus.truth_orig   = to_q;
  assign bus.truth_simp   = ts_q;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Purpose : self-checking bench for minterm_sweep_checker (N=3, SETTLE=1 and SETTLE=0 instances).
// Latency : expectations queued at each start, compared when done rises.
// Backpressure: start is pulsed; mid-sweep start pokes must be ignored.
module tb_minterm_sweep_checker;

  logic clk;
  logic rst_n;
  logic start_a;
  logic start_b;
  logic sel;
  int   mode;
  int   n_checks;
  int   n_err;

  minterm_sweep_checker_if #(.N(3)) bus_a ();
  minterm_sweep_checker_if #(.N(3)) bus_b ();

  minterm_sweep_checker #(.N(3), .SETTLE(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  minterm_sweep_checker #(.N(3), .SETTLE(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Circuits under comparison: F = AB + AB'C against a selectable "simplified" form.
  function automatic logic f_orig_m(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & ~v[1] & v[0]);
  endfunction

  function automatic logic f_simp_m(input int m, input logic [2:0] v);
    case (m)
      1:       return v[2] & v[1];
      2:       return 1'b1;
      default: return v[2] & (v[1] | v[0]);
    endcase
  endfunction

  assign bus_a.start  = start_a;
  assign bus_b.start  = start_b;
  assign bus_a.f_orig = f_orig_m(bus_a.abc);
  assign bus_b.f_orig = f_orig_m(bus_b.abc);
  assign bus_a.f_simp = f_simp_m(mode, bus_a.abc);
  assign bus_b.f_simp = f_simp_m(mode, bus_b.abc);

  // Observation view of whichever DUT is under test.
  logic [2:0] m_abc, m_ff;
  logic [3:0] m_cnt;
  logic [7:0] m_to, m_ts;
  logic       m_busy, m_done, m_pass;
  assign m_abc  = sel ? bus_b.abc          : bus_a.abc;
  assign m_ff   = sel ? bus_b.first_fail   : bus_a.first_fail;
  assign m_cnt  = sel ? bus_b.mismatch_cnt : bus_a.mismatch_cnt;
  assign m_to   = sel ? bus_b.truth_orig   : bus_a.truth_orig;
  assign m_ts   = sel ? bus_b.truth_simp   : bus_a.truth_simp;
  assign m_busy = sel ? bus_b.busy         : bus_a.busy;
  assign m_done = sel ? bus_b.done         : bus_a.done;
  assign m_pass = sel ? bus_b.pass         : bus_a.pass;

  typedef struct {
    logic [7:0] to;
    logic [7:0] ts;
    logic [3:0] cnt;
    logic [2:0] ff;
    logic       pass;
    int         cycles;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_abc"},  32'(m_abc),  0);
    check({tag, "_busy"}, 32'(m_busy), 0);
    check({tag, "_done"}, 32'(m_done), 0);
    check({tag, "_pass"}, 32'(m_pass), 0);
    check({tag, "_cnt"},  32'(m_cnt),  0);
    check({tag, "_ff"},   32'(m_ff),   0);
    check({tag, "_to"},   32'(m_to),   0);
    check({tag, "_ts"},   32'(m_ts),   0);
  endtask

  // Queue the model's expectation, launch a sweep, optionally poke start mid-sweep,
  // then compare everything once done rises.
  task automatic run_sweep(input int m, input int exp_cyc, input int poke);
    exp_t e;
    int   cyc;
    logic fo, fs;
    mode   = m;
    e.to   = '0;
    e.ts   = '0;
    e.cnt  = '0;
    e.ff   = '0;
    for (int v = 0; v < 8; v++) begin
      fo = f_orig_m(3'(v));
      fs = f_simp_m(m, 3'(v));
      e.to[v] = fo;
      e.ts[v] = fs;
      if (fo != fs) begin
        if (e.cnt == 0) e.ff = 3'(v);
        e.cnt = e.cnt + 4'd1;
      end
    end
    e.pass   = (e.cnt == 0);
    e.cycles = exp_cyc;
    sb.push_back(e);

    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0);
    cyc = 0;
    check("busy_e0",  32'(m_busy), 1);
    check("done_clr", 32'(m_done), 0);
    check("pass_clr", 32'(m_pass), 0);
    check("abc_e0",   32'(m_abc),  0);
    while (!m_done && cyc < 100) begin
      if (poke > 0 && cyc == poke - 1) set_start(1'b1);
      else                             set_start(1'b0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (sel && !m_done) check("abc_step", 32'(m_abc), 32'(cyc[2:0]));
    end
    set_start(1'b0);
    check("done_seen", 32'(m_done), 1);

    e = sb.pop_front();
    check("latency",      32'(cyc),    32'(e.cycles));
    check("busy_at_done", 32'(m_busy), 0);
    check("truth_orig",   32'(m_to),   32'(e.to));
    check("truth_simp",   32'(m_ts),   32'(e.ts));
    check("mismatch_cnt", 32'(m_cnt),  32'(e.cnt));
    check("first_fail",   32'(m_ff),   32'(e.ff));
    check("pass",         32'(m_pass), 32'(e.pass));
    check("abc_hold",     32'(m_abc),  7);
  endtask

  initial begin
    int guard;
    n_checks = 0;
    n_err    = 0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    sel      = 1'b0;
    mode     = 0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    sel = 1'b0;
    check_all_zero("rst_a");
    sel = 1'b1;
    check_all_zero("rst_b");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // SETTLE=1 instance: equivalent, injected bug, stuck-at-1.
    sel = 1'b0;
    run_sweep(0, 16, 0);
    run_sweep(1, 16, 0);
    run_sweep(2, 16, 0);
    // Start at +5 while busy must not disturb the sweep; then restart from DONE.
    run_sweep(0, 16, 5);
    run_sweep(1, 16, 0);

    // SETTLE=0 instance: one vector per edge.
    sel = 1'b1;
    run_sweep(0, 8, 0);

    // Reset mid-sweep on the SETTLE=1 instance with partially filled truth tables.
    sel  = 1'b0;
    mode = 2;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0);
    guard = 0;
    while (m_abc != 3'd3 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("reach_abc3", 32'(m_abc), 3);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(m_busy), 0);
    check("idle_done", 32'(m_done), 0);
    check("idle_abc",  32'(m_abc),  0);
    check("sb_empty",  32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
